// File: rtl/uart_pkg.sv
// Shared types and encodings for the UART TX path (and a future RX block).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_9BIT = 2'b11;

  localparam logic [1:0] DLEN_5 = 2'b00;
  localparam logic [1:0] DLEN_6 = 2'b01;
  localparam logic [1:0] DLEN_7 = 2'b10;
  localparam logic [1:0] DLEN_8 = 2'b11;

  localparam int unsigned MIN_DIV = 3;
  localparam int unsigned LEN_W   = 4;

  // Data bits per frame; 9 only for a 9-bit build in no-parity/9-bit mode, clamped to data_w.
  function automatic logic [LEN_W-1:0] frame_len(input logic [1:0]   dl,
                                                 input logic [1:0]   pm,
                                                 input int unsigned  data_w);
    logic [LEN_W-1:0] n;
    n = LEN_W'(5) + LEN_W'(dl);
    if (data_w == 9 && dl == DLEN_8 && pm == PAR_9BIT) n = LEN_W'(9);
    if (n > LEN_W'(data_w)) n = LEN_W'(data_w);
    return n;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; shared by UART TX/RX paths.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Flush wins over any simultaneous push or pop.
  assign push_ok = push && !full_q && !flush;
  assign pop_ok  = pop && !empty_q && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LW'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO. Optional CTS flow control under macro UART_TX_CTS_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_len,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          flush,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d;
  logic [LEN_W-1:0]   bit_q, bit_d, len_q, len_d;
  logic [1:0]         pmode_q, pmode_d;
  logic               stop2_q, stop2_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q;
  logic               load;
  logic               send_ok;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d,
                                       input logic [LEN_W-1:0]  n,
                                       input logic              odd);
    logic p;
    p = odd;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (LEN_W'(i) < n) p = p ^ d[i];
    end
    return p;
  endfunction

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n};
  end
  assign send_ok = ~cts_sync_q[1];
`else
  assign send_ok = 1'b1;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid && s_ready),
    .pop   (load),
    .flush (flush),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    len_d   = len_q;
    pmode_d = pmode_q;
    stop2_d = stop2_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && send_ok) load = 1'b1;
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = div_q;
          bit_d   = '0;
        end else cnt_d = cnt_q - DIV_W'(1);
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + LEN_W'(1);
          if (bit_q == len_q - LEN_W'(1)) begin
            state_d = (pmode_q == PAR_ODD || pmode_q == PAR_EVEN) ? PARITY : STOP;
            bit_d   = '0;
          end
        end else cnt_d = cnt_q - DIV_W'(1);
      end
      PARITY: begin
        if (cnt_q == '0) begin
          state_d = STOP;
          cnt_d   = div_q;
          bit_d   = '0;
        end else cnt_d = cnt_q - DIV_W'(1);
      end
      STOP: begin
        // bit_q counts stop bits so a second one can follow when stop2 is latched.
        if (cnt_q == '0) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = LEN_W'(1);
            cnt_d = div_q;
          end else if (!fifo_empty && send_ok) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else cnt_d = cnt_q - DIV_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      cnt_d   = baud_div;
      div_d   = baud_div;
      len_d   = frame_len(data_len, parity_mode, DATA_W);
      pmode_d = parity_mode;
      stop2_d = stop2;
      shreg_d = fifo_rdata;
      par_d   = calc_parity(fifo_rdata, len_d, parity_mode == PAR_ODD);
      bit_d   = '0;
    end
  end

  // Line level follows the registered state, so tx trails the state by one clock.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      pmode_q <= PAR_NONE;
      stop2_q <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      pmode_q <= pmode_d;
      stop2_q <= stop2_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign s_ready = ~fifo_full;

  a_min_div: assert property (@(posedge clk) disable iff (!rst_n)
                              load |-> (baud_div >= DIV_W'(MIN_DIV)));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame vectors plus FIFO, back-to-back, flush and reset sequences.
module tb_uart_tx_fifo;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV_W      = 16;

  logic              clk;
  logic              rst_n;
  logic              cts_n;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        data_len;
  logic [1:0]        parity_mode;
  logic              stop2;
  logic              flush;
  logic              tx;
  logic              busy;
  logic [2:0]        fifo_level;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [7:0] rxq [$];

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef UART_TX_CTS_EN
    .cts_n       (cts_n),
`endif
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .baud_div    (baud_div),
    .data_len    (data_len),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .flush       (flush),
    .tx          (tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  dlen;
    logic [1:0]  pmode;
    logic        stop2;
    int          nbits;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send_word(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, 32'(busy), 32'(0));
  endtask

  task automatic set_cfg(input logic [1:0] dl, input logic [1:0] pm, input logic s2);
    baud_div    = 16'd3;
    data_len    = dl;
    parity_mode = pm;
    stop2       = s2;
  endtask

  // 8N1 receiver at 4 clocks per bit; used only while mon_en is set.
  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (mon_en && rst_n && tx == 1'b0) begin
        repeat (6) @(posedge clk);
        #1;
        b[0] = tx;
        for (int j = 1; j < 8; j++) begin
          repeat (4) @(posedge clk);
          #1;
          b[j] = tx;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("mon_stop_bit", 32'(tx), 32'(1));
        rxq.push_back(b);
        @(posedge clk);
      end
    end
  end

  initial begin
    logic [21:0] patt;
    logic [7:0]  exp_ord [5];
    int          idx;
    logic        rdy;
    bit          ok;

    vecs[0] = '{8'hA5, 2'b11, 2'b00, 1'b0, 10, 16'({1'b1, 8'hA5, 1'b0})};
    vecs[1] = '{8'h03, 2'b10, 2'b01, 1'b0, 10, 16'({1'b1, 1'b1, 7'h03, 1'b0})};
    vecs[2] = '{8'h07, 2'b11, 2'b10, 1'b0, 11, 16'({1'b1, 1'b1, 8'h07, 1'b0})};
    vecs[3] = '{8'h3C, 2'b00, 2'b00, 1'b1,  8, 16'({2'b11, 5'h1C, 1'b0})};
    vecs[4] = '{8'h5A, 2'b01, 2'b10, 1'b0,  9, 16'({1'b1, 1'b1, 6'h1A, 1'b0})};
    vecs[5] = '{8'hFF, 2'b11, 2'b01, 1'b0, 11, 16'({1'b1, 1'b1, 8'hFF, 1'b0})};
    vecs[6] = '{8'h80, 2'b11, 2'b10, 1'b1, 12, 16'({2'b11, 1'b1, 8'h80, 1'b0})};
    vecs[7] = '{8'h01, 2'b11, 2'b11, 1'b0, 10, 16'({1'b1, 8'h01, 1'b0})};

    rst_n   = 1'b1;
    cts_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    flush   = 1'b0;
    set_cfg(2'b11, 2'b00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(s_ready), 32'(1));
    chk("rst_level", 32'(fifo_level), 32'(0));
    #24 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven single frames; config is scrambled after the pop to prove it was latched.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      set_cfg(v.dlen, v.pmode, v.stop2);
      @(posedge clk); #1;
      send_word(v.data);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy_on_pop", i), 32'(busy), 32'(1));
      chk($sformatf("vec%0d_tx_before_start", i), 32'(tx), 32'(1));
      baud_div    = 16'd7;
      data_len    = ~v.dlen;
      parity_mode = ~v.pmode;
      stop2       = ~v.stop2;
      for (int j = 0; j < v.nbits * 4; j++) begin
        @(posedge clk); #1;
        chk($sformatf("vec%0d_clk%0d", i, j), 32'(tx), 32'(v.exp[j/4]));
      end
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle_tx", i), 32'(tx), 32'(1));
      chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'(0));
    end

    // FIFO fill while busy: 4 entries accepted, then back-pressure, words sent in order.
    set_cfg(2'b11, 2'b00, 1'b0);
    rxq.delete();
    mon_en = 1'b1;
    send_word(8'h11);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      s_data  = 8'h21 + 8'(idx);
      s_valid = (idx < 6);
      rdy     = s_ready;
      @(posedge clk); #1;
      if (rdy && s_valid) begin
        idx++;
        if (idx == 4) begin
          chk("fill_ready_low", 32'(s_ready), 32'(0));
          chk("fill_level4", 32'(fifo_level), 32'(4));
        end
      end
    end
    s_valid = 1'b0;
    chk("fill_accepted", 32'(idx), 32'(4));
    chk("fill_level_hold", 32'(fifo_level), 32'(4));
    wait_idle("fill_drain_timeout", 400);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    exp_ord = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
    chk("fill_rx_count", 32'(rxq.size()), 32'(5));
    for (int i = 0; i < 5 && i < rxq.size(); i++)
      chk($sformatf("fill_order%0d", i), 32'(rxq[i]), 32'(exp_ord[i]));

    // Back-to-back 8N2 frames: no gap, and push+pop on one edge keeps the level.
    set_cfg(2'b11, 2'b00, 1'b1);
    @(posedge clk); #1;
    send_word(8'h11);
    send_word(8'h22);
    chk("b2b_level_pushpop", 32'(fifo_level), 32'(1));
    patt = {2'b11, 8'h22, 1'b0, 2'b11, 8'h11, 1'b0};
    ok = 1'b1;
    for (int j = 0; j < 88; j++) begin
      @(posedge clk); #1;
      if (tx !== patt[j/4]) begin
        ok = 1'b0;
        chk($sformatf("b2b_clk%0d", j), 32'(tx), 32'(patt[j/4]));
      end
    end
    chk("b2b_all_clocks", 32'(ok), 32'(1));
    @(posedge clk); #1;
    chk("b2b_idle_tx", 32'(tx), 32'(1));
    chk("b2b_idle_busy", 32'(busy), 32'(0));

    // Flush mid-frame: queue emptied, simultaneous push dropped, current frame finishes.
    set_cfg(2'b11, 2'b00, 1'b0);
    send_word(8'h33);
    send_word(8'h44);
    send_word(8'h55);
    chk("flush_level_before", 32'(fifo_level), 32'(2));
    s_data  = 8'h66;
    s_valid = 1'b1;
    flush   = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    flush   = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'(0));
    chk("flush_busy_kept", 32'(busy), 32'(1));
    wait_idle("flush_frame_timeout", 100);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("flush_no_more_frames", 32'(ok), 32'(1));

    // Reset during data bit 3 of 0xF0 with a second word queued.
    send_word(8'hF0);
    send_word(8'h0F);
    repeat (18) @(posedge clk);
    #1;
    chk("rst_mid_bit3_low", 32'(tx), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(tx), 32'(1));
    chk("rst_mid_level", 32'(fifo_level), 32'(0));
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_ready", 32'(s_ready), 32'(1));
    #3 rst_n = 1'b1;
    ok = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) ok = 1'b0;
    end
    chk("rst_no_resume", 32'(ok), 32'(1));
    send_word(8'h5A);
    @(posedge clk); #1;
    chk("rst_new_busy", 32'(busy), 32'(1));
    @(posedge clk); #1;
    chk("rst_new_start", 32'(tx), 32'(0));
    wait_idle("rst_new_timeout", 100);

`ifdef UART_TX_CTS_EN
    // Flow control: word held while cts_n high, released once cts_n drops.
    cts_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_word(8'h55);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("cts_hold", 32'(ok), 32'(1));
    cts_n = 1'b0;
    idx = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (tx == 1'b0) begin
        idx = k;
        break;
      end
    end
    chk("cts_start_seen", 32'(idx != 0 && idx <= 4), 32'(1));
    wait_idle("cts_frame_timeout", 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
